// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared external ripple-carry adder.
// Each accepted operation runs IDLE -> EXEC -> RESP, and the result is held until it is taken.
module adder_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req0_cin,
  input  logic             req1_cin,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_cout,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_z,
  output logic             resp_cout,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   last_r;
  logic   grant1_s;
  logic   accept_s;

  // Grant selection, accept qualification and next-state decode
  always_comb begin
    grant1_s     = 1'b0;
    accept_s     = 1'b0;
    state_next_s = state_r;
    if (req0_valid && req1_valid) begin
      grant1_s = ~last_r;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant1_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        accept_s = req0_valid | req1_valid;
        if (accept_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Readies are combinational; gating with reset keeps every output low while reset is held
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset && accept_s) begin
      req0_ready = ~grant1_s;
      req1_ready = grant1_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // State, round-robin pointer, and status flags registered from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      resp_valid <= (state_next_s == RESP);
      busy       <= (state_next_s != IDLE);
      if (accept_s) begin
        last_r <= grant1_s;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // Adder operands load only on accept, so they stay stable through EXEC and RESP
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      add_x   <= {WIDTH{1'b0}};
      add_y   <= {WIDTH{1'b0}};
      add_cin <= 1'b0;
      resp_id <= 1'b0;
    end else if (accept_s) begin
      add_x   <= grant1_s ? req1_x : req0_x;
      add_y   <= grant1_s ? req1_y : req0_y;
      add_cin <= grant1_s ? req1_cin : req0_cin;
      resp_id <= grant1_s;
    end else begin
      add_x   <= add_x;
      add_y   <= add_y;
      add_cin <= add_cin;
      resp_id <= resp_id;
    end
  end

  // The adder result is captured once, on the edge leaving EXEC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_z    <= {WIDTH{1'b0}};
      resp_cout <= 1'b0;
    end else if (state_r == EXEC) begin
      resp_z    <= add_z;
      resp_cout <= add_cout;
    end else begin
      resp_z    <= resp_z;
      resp_cout <= resp_cout;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised and directed bench for adder_arbiter, checked every cycle against a
// transaction-level model: one outstanding operation, its age, and the round-robin pointer.
module tb_adder_arbiter;
  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic req0_cin = 1'b0, req1_cin = 1'b0;
  logic req0_ready, req1_ready;
  logic [WIDTH-1:0] add_x, add_y, add_z, resp_z;
  logic add_cin, add_cout, resp_valid, resp_id, resp_cout, busy;
  logic resp_ready = 1'b0;
  logic [WIDTH:0] sum_s;

  adder_arbiter #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_z(add_z), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_z(resp_z),
    .resp_cout(resp_cout), .resp_ready(resp_ready), .busy(busy)
  );

  // The shared external adder
  assign sum_s = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_z = sum_s[WIDTH-1:0];
  assign add_cout = sum_s[WIDTH];

  always #5 clock = ~clock;

  int total_cnt = 0;
  int pass_cnt = 0;

  // Model: at most one operation in flight; age 0 = adder working, age 1 = response offered
  bit m_has;
  int m_age, m_id, m_last, m_x, m_y, m_cin;

  // Last sampled DUT outputs, for the directed literal checks
  int s_ready0, s_ready1, s_resp_valid, s_resp_z, s_resp_cout, s_resp_id, s_add_x, s_busy;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_has = 1'b0; m_age = 0; m_id = 0; m_last = 1;
    m_x = 0; m_y = 0; m_cin = 0;
  endtask

  task automatic cycle(input bit v0, input int x0, input int y0, input bit c0,
                       input bit v1, input int x1, input int y1, input bit c1,
                       input bit rr);
    bit e_r0, e_r1;
    int mask, full;
    @(negedge clock);
    req0_valid = v0; req0_x = WIDTH'(x0); req0_y = WIDTH'(y0); req0_cin = c0;
    req1_valid = v1; req1_x = WIDTH'(x1); req1_y = WIDTH'(y1); req1_cin = c1;
    resp_ready = rr;
    #1;
    e_r0 = !m_has && v0 && (!v1 || m_last == 1);
    e_r1 = !m_has && v1 && (!v0 || m_last == 0);
    chk("req0_ready", int'(req0_ready), int'(e_r0));
    chk("req1_ready", int'(req1_ready), int'(e_r1));
    chk("busy", int'(busy), int'(m_has));
    chk("resp_valid", int'(resp_valid), int'(m_has && m_age >= 1));
    chk("add_x", int'(add_x), m_x);
    chk("add_y", int'(add_y), m_y);
    chk("add_cin", int'(add_cin), m_cin);
    if (m_has && m_age >= 1) begin
      mask = (1 << WIDTH) - 1;
      full = m_x + m_y + m_cin;
      chk("resp_z", int'(resp_z), full & mask);
      chk("resp_cout", int'(resp_cout), full >> WIDTH);
      chk("resp_id", int'(resp_id), m_id);
    end
    s_ready0 = req0_ready; s_ready1 = req1_ready; s_resp_valid = resp_valid;
    s_resp_z = resp_z; s_resp_cout = resp_cout; s_resp_id = resp_id;
    s_add_x = add_x; s_busy = busy;
    @(posedge clock);
    if (m_has) begin
      if (m_age >= 1 && rr) m_has = 1'b0;
      else m_age = 1;
    end else if (e_r0 || e_r1) begin
      m_has = 1'b1; m_age = 0;
      m_id = e_r1 ? 1 : 0; m_last = m_id;
      m_x = e_r1 ? x1 : x0; m_y = e_r1 ? y1 : y0; m_cin = e_r1 ? c1 : c0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_add", int'({add_x, add_y, add_cin}), 0);
    chk("rst_resp", int'({resp_z, resp_cout, resp_id}), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
  endtask

  int grants[$];

  initial begin
    model_reset();
    do_reset();

    // Single requester 0: 3 + 4 + 0
    cycle(1, 3, 4, 0, 0, 0, 0, 0, 1);
    chk("lit026_ready0", s_ready0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit026_exec_novalid", s_resp_valid, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit026_valid", s_resp_valid, 1);
    chk("lit026_z", s_resp_z, 7);
    chk("lit026_cout", s_resp_cout, 0);
    chk("lit026_id", s_resp_id, 0);

    // Single requester 1: 15 + 1 + 1 wraps
    cycle(0, 0, 0, 0, 1, 15, 1, 1, 1);
    chk("lit027_ready1", s_ready1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit027_z", s_resp_z, 1);
    chk("lit027_cout", s_resp_cout, 1);
    chk("lit027_id", s_resp_id, 1);

    // Both valid continuously after reset: grants alternate starting with 0
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1, i, 1, 0, 1, i, 2, 1, 1);
      if (s_ready0) grants.push_back(0);
      if (s_ready1) grants.push_back(1);
    end
    chk("lit028_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("lit028_grant", grants[i], i % 2);

    // Response stalled for 5 cycles
    do_reset();
    cycle(1, 5, 9, 1, 0, 0, 0, 0, 0);
    cycle(1, 5, 9, 1, 1, 7, 7, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, 0, 1, 2, 2, 0, 0);
      chk("lit029_valid", s_resp_valid, 1);
      chk("lit029_z", s_resp_z, 15);
      chk("lit029_add_x", s_add_x, 5);
      chk("lit029_readies", s_ready0 + s_ready1, 0);
    end
    cycle(1, 1, 1, 0, 1, 2, 2, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("lit029_idle", s_busy, 0);

    // Reset during EXEC aborts the operation
    cycle(1, 2, 2, 0, 0, 0, 0, 0, 1);
    chk("lit030_accept", s_ready0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("lit030_no_resp", s_resp_valid, 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 1) == 1,
            ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
